// File: rtl/pe_conv_acc.sv
// pe_conv_acc: N x N masked signed MAC window accumulated over a configurable
// number of input channels, followed by bias, rounding shift, optional ReLU
// and saturation. One output pixel per nch accepted beats.
//
// Handshakes (cfg, in, out) are valid/ready: a transfer happens on the rising
// edge where both valid and ready are high. Ready never depends on valid.
// Valid is never withdrawn by this block while waiting for ready.
module pe_conv_acc #(
   parameter int DATA_WIDTH  = 8,
   parameter int N           = 6,
   parameter int ACC_WIDTH   = 32,
   parameter int SHIFT_WIDTH = 4
) (
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   input  logic                         i_flush,
   input  logic                         i_cfg_valid,
   output logic                         o_cfg_ready,
   input  logic [$clog2(N+1)-1:0]       i_cfg_ksize,
   input  logic [7:0]                   i_cfg_nch,
   input  logic [SHIFT_WIDTH-1:0]       i_cfg_shift,
   input  logic                         i_cfg_relu,
   input  logic [DATA_WIDTH-1:0]        i_cfg_bias,
   input  logic                         i_in_valid,
   output logic                         o_in_ready,
   input  logic [N*N*DATA_WIDTH-1:0]    i_in_img,
   input  logic [N*N*DATA_WIDTH-1:0]    i_in_wgt,
   output logic                         o_out_valid,
   input  logic                         i_out_ready,
   output logic [DATA_WIDTH-1:0]        o_out_data,
   output logic                         o_busy,
   output logic [1:0]                   o_dbg_state
);
   localparam int KW = $clog2(N+1);
   localparam int NE = N*N;
   localparam int PW = 2*DATA_WIDTH;
   localparam int SW = PW + $clog2(NE);
   localparam int OW = ACC_WIDTH + 2;
   localparam logic signed [OW-1:0] SAT_MAX = OW'((2**(DATA_WIDTH-1)) - 1);
   localparam logic signed [OW-1:0] SAT_MIN = ~SAT_MAX;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2, S_OUT = 2'd3} state_t;

   state_t                         state_q, state_d;
   logic [KW-1:0]                  ksize_q;
   logic [7:0]                     nch_q;
   logic [SHIFT_WIDTH-1:0]         shift_q;
   logic                           relu_q;
   logic signed [DATA_WIDTH-1:0]   bias_q;
   logic [7:0]                     beat_cnt_q;
   logic [NE*DATA_WIDTH-1:0]       img_q, wgt_q;
   logic                           v0_q, v1_q, v2_q;
   logic signed [PW-1:0]           prod_d [NE];
   logic signed [PW-1:0]           prod_q [NE];
   logic signed [SW-1:0]           sum_d, sum_q;
   logic signed [ACC_WIDTH-1:0]    acc_q;
   logic                           out_valid_q;
   logic [DATA_WIDTH-1:0]          out_data_q;
   logic [DATA_WIDTH-1:0]          res_d;
   logic signed [OW-1:0]           t_sum, r_sh, rnd;

   logic cfg_fire, in_fire, out_fire, last_beat, pipe_empty, load_out;
   logic [KW-1:0] ksize_eff;

   assign cfg_fire   = o_cfg_ready && i_cfg_valid && !i_flush;
   assign in_fire    = o_in_ready && i_in_valid && !i_flush;
   assign out_fire   = (state_q == S_OUT) && i_out_ready && !i_flush;
   assign last_beat  = in_fire && ((beat_cnt_q + 8'd1) == nch_q);
   assign pipe_empty = !v0_q && !v1_q && !v2_q;
   assign load_out   = (state_q == S_DRAIN) && pipe_empty && !i_flush;
   assign ksize_eff  = ((i_cfg_ksize == '0) || (i_cfg_ksize > KW'(N))) ? KW'(N) : i_cfg_ksize;

   // State register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   // Next-state: flush dominates, DRAIN waits for the three pipeline stages to empty
   always_comb begin
      state_d = state_q;
      if (i_flush) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:  if (i_cfg_valid) state_d = S_RUN;
            S_RUN:   if (last_beat)   state_d = S_DRAIN;
            S_DRAIN: if (pipe_empty)  state_d = S_OUT;
            S_OUT:   if (i_out_ready) state_d = S_RUN;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // State-decoded outputs
   always_comb begin
      o_cfg_ready = (state_q == S_IDLE);
      o_in_ready  = (state_q == S_RUN);
      o_busy      = (state_q != S_IDLE);
      o_dbg_state = state_q;
   end

   // Layer configuration, latched once per cfg handshake and reused for every pixel
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ksize_q <= KW'(N);
         nch_q   <= 8'd1;
         shift_q <= '0;
         relu_q  <= 1'b0;
         bias_q  <= '0;
      end else if (cfg_fire) begin
         ksize_q <= ksize_eff;
         nch_q   <= (i_cfg_nch == 8'd0) ? 8'd1 : i_cfg_nch;
         shift_q <= i_cfg_shift;
         relu_q  <= i_cfg_relu;
         bias_q  <= i_cfg_bias;
      end
   end

   // Beat counter: restarts at every new pixel
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)                 beat_cnt_q <= '0;
      else if (cfg_fire || out_fire) beat_cnt_q <= '0;
      else if (in_fire)             beat_cnt_q <= beat_cnt_q + 8'd1;
   end

   // Masked products: elements outside the k x k corner contribute zero
   always_comb begin
      for (int i = 0; i < NE; i++) prod_d[i] = '0;
      for (int r = 0; r < N; r++) begin
         for (int c = 0; c < N; c++) begin
            if ((r < int'(ksize_q)) && (c < int'(ksize_q))) begin
               prod_d[r*N+c] = $signed(img_q[(r*N+c)*DATA_WIDTH +: DATA_WIDTH])
                             * $signed(wgt_q[(r*N+c)*DATA_WIDTH +: DATA_WIDTH]);
            end
         end
      end
   end

   // Adder tree over all products, sign-extended to the tree width
   always_comb begin
      sum_d = '0;
      for (int i = 0; i < NE; i++) sum_d = sum_d + SW'(prod_q[i]);
   end

   // Beat pipeline: input capture (E0), products (E1), tree sum (E2); flush drops in-flight beats
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         v0_q  <= 1'b0;
         v1_q  <= 1'b0;
         v2_q  <= 1'b0;
         img_q <= '0;
         wgt_q <= '0;
         sum_q <= '0;
         for (int i = 0; i < NE; i++) prod_q[i] <= '0;
      end else begin
         v0_q <= in_fire;
         v1_q <= v0_q && !i_flush;
         v2_q <= v1_q && !i_flush;
         if (in_fire) begin
            img_q <= i_in_img;
            wgt_q <= i_in_wgt;
         end
         if (v0_q) begin
            for (int i = 0; i < NE; i++) prod_q[i] <= prod_d[i];
         end
         if (v1_q) sum_q <= sum_d;
      end
   end

   // Accumulator (E3): wraps modulo 2^ACC_WIDTH, cleared at each new pixel
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)                  acc_q <= '0;
      else if (cfg_fire || out_fire) acc_q <= '0;
      else if (v2_q)                 acc_q <= acc_q + ACC_WIDTH'(sum_q);
   end

   // Output stage: bias scaled into the accumulator domain, round half up, ReLU, saturate
   always_comb begin
      rnd = '0;
      if (shift_q != '0) rnd = OW'(1) << (shift_q - SHIFT_WIDTH'(1));
      t_sum = OW'(acc_q) + (OW'(bias_q) <<< shift_q) + rnd;
      r_sh  = t_sum >>> shift_q;
      if (relu_q && r_sh[OW-1]) r_sh = '0;
      if (r_sh > SAT_MAX)      r_sh = SAT_MAX;
      else if (r_sh < SAT_MIN) r_sh = SAT_MIN;
      res_d = r_sh[DATA_WIDTH-1:0];
   end

   // Output register: loads when DRAIN sees an empty pipeline, holds until accepted
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else if (i_flush) begin
         out_valid_q <= 1'b0;
      end else if (load_out) begin
         out_valid_q <= 1'b1;
         out_data_q  <= res_d;
      end else if (out_fire) begin
         out_valid_q <= 1'b0;
      end
   end

   assign o_out_valid = out_valid_q;
   assign o_out_data  = out_data_q;

endmodule

// File: tb/tb_pe_conv_acc.sv
// Bench for pe_conv_acc: directed scenarios plus randomized pixels checked
// against an arithmetic reference model of the window sum and output stage.
module tb_pe_conv_acc;
   localparam int DW  = 8;
   localparam int N   = 6;
   localparam int AW  = 32;
   localparam int SHW = 4;
   localparam int KW  = $clog2(N+1);
   localparam int VW  = N*N*DW;

   logic             i_clk = 1'b0;
   logic             i_rst_n = 1'b0;
   logic             i_flush = 1'b0;
   logic             i_cfg_valid = 1'b0;
   logic             o_cfg_ready;
   logic [KW-1:0]    i_cfg_ksize = '0;
   logic [7:0]       i_cfg_nch = '0;
   logic [SHW-1:0]   i_cfg_shift = '0;
   logic             i_cfg_relu = 1'b0;
   logic [DW-1:0]    i_cfg_bias = '0;
   logic             i_in_valid = 1'b0;
   logic             o_in_ready;
   logic [VW-1:0]    i_in_img = '0;
   logic [VW-1:0]    i_in_wgt = '0;
   logic             o_out_valid;
   logic             i_out_ready = 1'b0;
   logic [DW-1:0]    o_out_data;
   logic             o_busy;
   logic [1:0]       o_dbg_state;

   int n_checks = 0;
   int n_fail   = 0;

   logic [VW-1:0] beat_img[$];
   logic [VW-1:0] beat_wgt[$];
   logic [DW-1:0] exp_q[$];

   int cur_k, cur_sh, cur_bias, cur_relu;

   pe_conv_acc #(.DATA_WIDTH(DW), .N(N), .ACC_WIDTH(AW), .SHIFT_WIDTH(SHW)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush),
      .i_cfg_valid(i_cfg_valid), .o_cfg_ready(o_cfg_ready),
      .i_cfg_ksize(i_cfg_ksize), .i_cfg_nch(i_cfg_nch), .i_cfg_shift(i_cfg_shift),
      .i_cfg_relu(i_cfg_relu), .i_cfg_bias(i_cfg_bias),
      .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
      .i_in_img(i_in_img), .i_in_wgt(i_in_wgt),
      .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_out_data(o_out_data),
      .o_busy(o_busy), .o_dbg_state(o_dbg_state)
   );

   // Clock
   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // Advance to 1 time unit after the next rising edge
   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   function automatic logic [VW-1:0] fill(input int v);
      logic [VW-1:0] f;
      for (int i = 0; i < N*N; i++) f[i*DW +: DW] = DW'(v);
      return f;
   endfunction

   function automatic logic [VW-1:0] rand_vec();
      logic [VW-1:0] f;
      for (int i = 0; i < N*N; i++) f[i*DW +: DW] = DW'($urandom);
      return f;
   endfunction

   // Reference: sum of k x k corner products over all beats, 32-bit wrap,
   // then bias/round/shift, ReLU and saturation on wide integers
   function automatic longint model_pixel();
      longint acc, t, res;
      int ke;
      logic [VW-1:0] vi, vw;
      acc = 0;
      ke  = (cur_k == 0 || cur_k > N) ? N : cur_k;
      for (int b = 0; b < beat_img.size(); b++) begin
         vi = beat_img[b];
         vw = beat_wgt[b];
         for (int r = 0; r < ke; r++)
            for (int c = 0; c < ke; c++)
               acc += longint'($signed(vi[(r*N+c)*DW +: DW])) * longint'($signed(vw[(r*N+c)*DW +: DW]));
      end
      acc = longint'(int'(acc));
      t = acc + (longint'(cur_bias) <<< cur_sh) + ((cur_sh > 0) ? (longint'(1) <<< (cur_sh - 1)) : 0);
      res = t >>> cur_sh;
      if (cur_relu != 0 && res < 0) res = 0;
      if (res > 127) res = 127;
      if (res < -128) res = -128;
      return res;
   endfunction

   task automatic close_pixel();
      exp_q.push_back(DW'(model_pixel()));
      beat_img.delete();
      beat_wgt.delete();
   endtask

   task automatic configure(input int k, input int nch, input int sh, input int relu, input int bias);
      cur_k = k; cur_sh = sh; cur_bias = bias; cur_relu = relu;
      i_cfg_ksize = KW'(k);
      i_cfg_nch   = 8'(nch);
      i_cfg_shift = SHW'(sh);
      i_cfg_relu  = (relu != 0);
      i_cfg_bias  = DW'(bias);
      check("cfg_ready_idle", o_cfg_ready, 1);
      i_cfg_valid = 1'b1;
      step();
      i_cfg_valid = 1'b0;
      check("busy_after_cfg", o_busy, 1);
      check("in_ready_run", o_in_ready, 1);
   endtask

   task automatic send_beat(input logic [VW-1:0] img, input logic [VW-1:0] wgt, input int gap);
      int guard;
      i_in_valid = 1'b0;
      repeat (gap) step();
      i_in_img = img;
      i_in_wgt = wgt;
      i_in_valid = 1'b1;
      guard = 0;
      while (!o_in_ready && guard < 20) begin
         step();
         guard++;
      end
      check("in_ready_beat", o_in_ready, 1);
      beat_img.push_back(img);
      beat_wgt.push_back(wgt);
      step();
      i_in_valid = 1'b0;
      i_in_img = rand_vec();
      i_in_wgt = rand_vec();
   endtask

   task automatic flush();
      i_flush = 1'b1;
      step();
      i_flush = 1'b0;
      check("flush_cfg_ready", o_cfg_ready, 1);
      check("flush_out_valid", o_out_valid, 0);
      check("flush_state_idle", o_dbg_state, 0);
      beat_img.delete();
      beat_wgt.delete();
   endtask

   task automatic wait_valid();
      int lat;
      lat = 0;
      while (!o_out_valid && lat < 30) begin
         step();
         lat++;
      end
      check("out_latency", lat, 4);
      check("out_valid", o_out_valid, 1);
   endtask

   // Called right after the last beat of a pixel
   task automatic collect(input int stall);
      logic [DW-1:0] expv;
      i_out_ready = 1'b0;
      wait_valid();
      expv = exp_q.pop_front();
      check("out_data", $signed(o_out_data), $signed(expv));
      for (int s = 0; s < stall; s++) begin
         step();
         check("hold_valid", o_out_valid, 1);
         check("hold_data", $signed(o_out_data), $signed(expv));
         check("hold_in_ready", o_in_ready, 0);
      end
      i_out_ready = 1'b1;
      step();
      i_out_ready = 1'b0;
      check("out_released", o_out_valid, 0);
      check("next_pixel_ready", o_in_ready, 1);
   endtask

   initial begin
      logic [VW-1:0] va, vb;
      int nch, k;

      // Reset
      i_rst_n = 1'b0;
      repeat (3) step();
      check("rst_out_valid", o_out_valid, 0);
      check("rst_out_data", o_out_data, 0);
      check("rst_in_ready", o_in_ready, 0);
      check("rst_busy", o_busy, 0);
      check("rst_cfg_ready", o_cfg_ready, 1);
      i_rst_n = 1'b1;
      step();

      // Basic: k=3, img=1, wgt=2 -> 18
      configure(3, 1, 0, 0, 0);
      send_beat(fill(1), fill(2), 0);
      close_pixel();
      collect(0);

      // Accumulate and round / saturate
      flush();
      configure(6, 4, 7, 0, 0);
      for (int b = 0; b < 4; b++) send_beat(fill(10), fill(10), 0);
      close_pixel();
      collect(0);
      flush();
      configure(6, 4, 6, 0, 0);
      for (int b = 0; b < 4; b++) send_beat(fill(10), fill(10), 0);
      close_pixel();
      collect(0);

      // Sign, bias, ReLU
      flush();
      configure(2, 1, 0, 0, 0);
      send_beat(fill(-3), fill(5), 0);
      close_pixel();
      collect(0);
      flush();
      configure(2, 1, 0, 1, 0);
      send_beat(fill(-3), fill(5), 0);
      close_pixel();
      collect(0);
      flush();
      configure(2, 1, 2, 0, 1);
      send_beat(fill(-3), fill(5), 0);
      close_pixel();
      collect(0);

      // Masking: k=1 with junk elsewhere; ksize=0 as full window; nch=0 as one beat
      flush();
      configure(1, 1, 0, 0, 0);
      va = rand_vec(); vb = rand_vec();
      va[DW-1:0] = 8'd7;
      vb[DW-1:0] = 8'hFC;
      send_beat(va, vb, 0);
      close_pixel();
      collect(0);
      flush();
      configure(0, 2, 8, 0, -5);
      send_beat(rand_vec(), rand_vec(), 0);
      send_beat(rand_vec(), rand_vec(), 1);
      close_pixel();
      collect(0);
      flush();
      configure(4, 0, 3, 0, 2);
      send_beat(rand_vec(), rand_vec(), 0);
      close_pixel();
      collect(0);

      // Backpressure then a second pixel with the same configuration
      flush();
      configure(5, 2, 9, 0, 3);
      send_beat(rand_vec(), rand_vec(), 0);
      send_beat(rand_vec(), rand_vec(), 0);
      close_pixel();
      collect(5);
      send_beat(rand_vec(), rand_vec(), 2);
      send_beat(rand_vec(), rand_vec(), 0);
      close_pixel();
      collect(1);

      // Randomized layers
      for (int it = 0; it < 10; it++) begin
         flush();
         k   = $urandom_range(0, 7);
         nch = $urandom_range(0, 5);
         configure(k, nch, $urandom_range(0, 15), $urandom_range(0, 1), int'($urandom_range(0, 255)) - 128);
         for (int p = 0; p < 2; p++) begin
            for (int b = 0; b < ((nch == 0) ? 1 : nch); b++)
               send_beat(rand_vec(), rand_vec(), $urandom_range(0, 2));
            close_pixel();
            collect($urandom_range(0, 3));
         end
      end

      // Abort after 2 of 4 beats, then a clean pixel
      flush();
      configure(6, 4, 10, 0, 0);
      send_beat(rand_vec(), rand_vec(), 0);
      send_beat(rand_vec(), rand_vec(), 0);
      flush();
      configure(6, 4, 10, 0, 0);
      for (int b = 0; b < 4; b++) send_beat(rand_vec(), rand_vec(), 0);
      close_pixel();
      collect(0);

      // Reset while a result is pending
      flush();
      configure(3, 1, 0, 0, 0);
      send_beat(rand_vec(), rand_vec(), 0);
      close_pixel();
      wait_valid();
      void'(exp_q.pop_front());
      #2;
      i_rst_n = 1'b0;
      #1;
      check("rst_mid_out_valid", o_out_valid, 0);
      check("rst_mid_busy", o_busy, 0);
      check("rst_mid_out_data", o_out_data, 0);
      #4;
      i_rst_n = 1'b1;
      step();
      check("rst_mid_cfg_ready", o_cfg_ready, 1);
      check("rst_mid_in_ready", o_in_ready, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
